// File: rtl/subleq_machine.sv
// 8-bit SUBLEQ core: PC, 256x8 RAM, operand registers and a six-cycle sequencer.
// Each instruction A,B,C computes mem[B] -= mem[A] and branches to C when the result is <= 0.
module subleq_machine #(
  parameter logic [7:0] HALT_ADDR = 8'hFF
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic [7:0] pc,
  output logic       busy,
  output logic       halted,
  output logic       instr_done
);

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 256;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_A, S_FETCH_B, S_READ_A, S_READ_B, S_WRITE, S_FETCH_C, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_LOAD = 2'b10,
    PC_CLR  = 2'b11
  } pc_op_t;

  state_t         state, state_next;
  pc_op_t         pc_op;
  logic [W-1:0]   mem [DEPTH];
  logic [W-1:0]   pc_q, ap, bp, a_a, a_b;
  logic           le;
  logic           ld_ap, ld_bp, ld_aa, ld_ab, exec_we;
  logic           prog_ok;
  logic [W-1:0]   rd_pc, rd_ap, rd_bp, diff;

  assign rd_pc    = mem[pc_q];
  assign rd_ap    = mem[ap];
  assign rd_bp    = mem[bp];
  assign diff     = W'(a_b - a_a);
  assign dbg_data = mem[dbg_addr];
  assign pc       = pc_q;
  assign prog_ok  = prog_we && (state == S_IDLE || state == S_HALT);

  // State register, datapath registers and registered status flags.
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= S_IDLE;
      pc_q       <= '0;
      ap         <= '0;
      bp         <= '0;
      a_a        <= '0;
      a_b        <= '0;
      le         <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != S_IDLE) && (state_next != S_HALT);
      halted     <= (state_next == S_HALT);
      instr_done <= (state_next == S_FETCH_C);
      if (ld_ap)   ap  <= rd_pc;
      if (ld_bp)   bp  <= rd_pc;
      if (ld_aa)   a_a <= rd_ap;
      if (ld_ab)   a_b <= rd_bp;
      if (exec_we) le  <= (diff == '0) | diff[W-1];
      case (pc_op)
        PC_HOLD: pc_q <= pc_q;
        PC_INC:  pc_q <= W'(pc_q + W'(1));
        PC_LOAD: pc_q <= rd_pc;
        PC_CLR:  pc_q <= '0;
      endcase
    end
  end

  // RAM write port: the execute write has priority; host loads only when not executing.
  always_ff @(posedge clk) begin
    if (exec_we && !res) begin
      mem[bp] <= diff;
    end else if (prog_ok) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Sequencer: one state per cycle, six cycles per instruction.
  always_comb begin
    state_next = state;
    pc_op      = PC_HOLD;
    ld_ap      = 1'b0;
    ld_bp      = 1'b0;
    ld_aa      = 1'b0;
    ld_ab      = 1'b0;
    exec_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH_A;
          pc_op      = PC_CLR;
        end
      end
      S_FETCH_A: begin
        ld_ap      = 1'b1;
        pc_op      = PC_INC;
        state_next = S_FETCH_B;
      end
      S_FETCH_B: begin
        ld_bp      = 1'b1;
        pc_op      = PC_INC;
        state_next = S_READ_A;
      end
      S_READ_A: begin
        ld_aa      = 1'b1;
        state_next = S_READ_B;
      end
      S_READ_B: begin
        ld_ab      = 1'b1;
        state_next = S_WRITE;
      end
      S_WRITE: begin
        exec_we    = 1'b1;
        state_next = S_FETCH_C;
      end
      S_FETCH_C: begin
        // C is read after the write, so self-modified targets take effect.
        if (le) begin
          pc_op      = PC_LOAD;
          state_next = (rd_pc == HALT_ADDR) ? S_HALT : S_FETCH_A;
        end else begin
          pc_op      = PC_INC;
          state_next = S_FETCH_A;
        end
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_subleq_machine.sv
// Directed bench for subleq_machine with an instruction-level reference model.
module tb_subleq_machine;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       start = 1'b0;
  logic       prog_we = 1'b0;
  logic [7:0] prog_addr = 8'h00;
  logic [7:0] prog_data = 8'h00;
  logic [7:0] dbg_addr = 8'h00;
  logic [7:0] dbg_data;
  logic [7:0] pc;
  logic       busy;
  logic       halted;
  logic       instr_done;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0 = idle/halted, 1..6 = cycle within an instruction.
  logic [7:0] m_mem [256];
  logic [7:0] m_pc = 8'h00;
  logic       m_halt = 1'b0;
  logic       m_le = 1'b0;
  int         m_phase = 0;

  subleq_machine dut (
    .clk(clk), .res(res), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .pc(pc), .busy(busy), .halted(halted),
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs that the DUT will sample.
  task automatic model_step();
    logic [7:0] a, b, c, r;
    if (res) begin
      m_phase = 0; m_halt = 1'b0; m_pc = 8'h00; m_le = 1'b0;
    end else begin
      if (prog_we && m_phase == 0) m_mem[prog_addr] = prog_data;
      case (m_phase)
        0: if (!m_halt && start) begin m_phase = 1; m_pc = 8'h00; end
        5: begin
          a = m_mem[m_pc];
          b = m_mem[8'(m_pc + 8'd1)];
          r = 8'(m_mem[b] - m_mem[a]);
          m_mem[b] = r;
          m_le = (r == 8'h00) || r[7];
          m_phase = 6;
        end
        6: begin
          c = m_mem[8'(m_pc + 8'd2)];
          if (m_le && c == 8'hFF) begin
            m_halt = 1'b1; m_pc = 8'hFF; m_phase = 0;
          end else begin
            m_pc = m_le ? c : 8'(m_pc + 8'd3);
            m_phase = 1;
          end
        end
        default: m_phase++;
      endcase
    end
  endtask

  // One clock: step the model, then compare every status output after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("busy", {7'd0, busy}, {7'd0, m_phase != 0});
    chk("halted", {7'd0, halted}, {7'd0, m_halt});
    chk("instr_done", {7'd0, instr_done}, {7'd0, m_phase == 6});
    if (m_phase <= 1) chk("pc", pc, m_pc);
  endtask

  task automatic load(input logic [7:0] addr, input logic [7:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic chk_mem(input string nm, input logic [7:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    chk(nm, dbg_data, exp);
    chk({nm, "_model"}, dbg_data, m_mem[addr]);
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick();
    tick();
    res = 1'b0;
  endtask

  task automatic run_prog(input int budget, output int d1, output int d2,
                          output logic [7:0] pc_i1, output logic [7:0] pc_i2);
    int cyc;
    d1 = 0; d2 = 0; pc_i1 = 8'h00; pc_i2 = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!halted && cyc < budget) begin
      tick();
      cyc++;
      if (instr_done) begin
        if (d1 == 0) d1 = cyc;
        else if (d2 == 0) d2 = cyc;
      end
      if (cyc == 7)  pc_i1 = pc;
      if (cyc == 13) pc_i2 = pc;
    end
    chk("halt_reached", {7'd0, halted}, 8'd1);
  endtask

  task automatic load_prog1();
    load(8'd0, 8'd10); load(8'd1, 8'd11); load(8'd2, 8'd3);
    load(8'd3, 8'd12); load(8'd4, 8'd12); load(8'd5, 8'd255);
    load(8'd10, 8'd3); load(8'd11, 8'd5); load(8'd12, 8'd7);
  endtask

  initial begin
    int d1, d2, cyc;
    logic [7:0] p1, p2;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

    // Reset state and RAM retention across reset.
    do_reset();
    chk("rst_pc", pc, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_halted", {7'd0, halted}, 8'd0);
    chk("rst_done", {7'd0, instr_done}, 8'd0);
    load(8'h40, 8'hA5);
    res = 1'b1;
    tick();
    chk_mem("dbg_in_reset", 8'h40, 8'hA5);
    tick();
    res = 1'b0;
    chk_mem("dbg_after_reset", 8'h40, 8'hA5);

    // Two-instruction program ending in HALT.
    load_prog1();
    run_prog(60, d1, d2, p1, p2);
    chk("p1_done1_cycle", 8'(d1), 8'd6);
    chk("p1_done2_cycle", 8'(d2), 8'd12);
    chk("p1_pc_after_i1", p1, 8'h03);
    chk("p1_pc_halt", p2, 8'hFF);
    chk_mem("p1_mem11", 8'd11, 8'h02);
    chk_mem("p1_mem12", 8'd12, 8'h00);
    chk("p1_halted", {7'd0, halted}, 8'd1);
    chk("p1_busy", {7'd0, busy}, 8'd0);
    chk("p1_pc", pc, 8'hFF);
    tick();
    tick();
    chk("p1_halt_stays", {7'd0, halted}, 8'd1);

    // Negative result branches to C.
    load(8'h00, 8'h50); load(8'h01, 8'h51); load(8'h02, 8'h20);
    load(8'h50, 8'h05); load(8'h51, 8'h03);
    load(8'h20, 8'h52); load(8'h21, 8'h52); load(8'h22, 8'hFF);
    do_reset();
    run_prog(60, d1, d2, p1, p2);
    chk("neg_pc_after_i1", p1, 8'h20);
    chk_mem("neg_mem51", 8'h51, 8'hFE);

    // 0x80 - 0x01 wraps to a positive value: no branch.
    load(8'h00, 8'h60); load(8'h01, 8'h61); load(8'h02, 8'h00);
    load(8'h03, 8'h62); load(8'h04, 8'h62); load(8'h05, 8'hFF);
    load(8'h60, 8'h01); load(8'h61, 8'h80);
    do_reset();
    run_prog(60, d1, d2, p1, p2);
    chk("wrap_pc_after_i1", p1, 8'h03);
    chk_mem("wrap_mem61", 8'h61, 8'h7F);

    // Instruction at 0xFE fetches C across the PC wrap from mem[0x00].
    load(8'h00, 8'h70); load(8'h01, 8'h70); load(8'h02, 8'hFE); load(8'h03, 8'h00);
    load(8'h04, 8'h73); load(8'h05, 8'h73); load(8'h06, 8'hFF);
    load(8'hFE, 8'h71); load(8'hFF, 8'h72);
    load(8'h71, 8'h01); load(8'h72, 8'h05);
    do_reset();
    run_prog(80, d1, d2, p1, p2);
    chk("pcwrap_pc_i1", p1, 8'hFE);
    chk("pcwrap_pc_i2", p2, 8'h01);
    chk_mem("pcwrap_mem72", 8'h72, 8'h04);
    chk_mem("pcwrap_memfe", 8'hFE, 8'h71);

    // Reset during READ_B of the first instruction suppresses its write.
    load_prog1();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    res = 1'b1;
    tick();
    res = 1'b0;
    chk_mem("abort_mem11", 8'd11, 8'h05);
    chk("abort_pc", pc, 8'h00);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_halted", {7'd0, halted}, 8'd0);

    // Restart from 0, with a host write attempted mid-run.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    prog_we = 1'b1; prog_addr = 8'h40; prog_data = 8'h11;
    tick();
    prog_we = 1'b0;
    cyc = 0;
    while (!halted && cyc < 40) begin tick(); cyc++; end
    chk("restart_halted", {7'd0, halted}, 8'd1);
    chk_mem("restart_mem11", 8'd11, 8'h02);
    chk_mem("protected_mem40", 8'h40, 8'hA5);
    load(8'h40, 8'h11);
    chk_mem("halt_load_mem40", 8'h40, 8'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
